// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between instruction memory and decode.
// Holds the program counter, keeps one outstanding req/ack read to imem, and
// buffers returned words with their PCs in a DEPTH-entry FIFO.
// When decode pops an instruction, Jmp/BranchAND/jr_target can redirect the
// fetch; a redirect flushes the FIFO and drops any read still in flight.
// Optional feature: define FETCH_BYPASS_EN to forward an ack straight to the
// decode port when the buffer is empty. Without it, inst* comes only from
// registers.
module fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic [1:0]  Jmp,
    input  logic        BranchAND,
    input  logic [31:0] jr_target
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // IDLE: no read outstanding; BUSY: read outstanding, data wanted;
    // DROP: read outstanding, but its data is stale after a redirect.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DROP = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        addr_q, addr_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        inst_mem_q [DEPTH];
    logic [31:0]        pc_mem_q   [DEPTH];

    logic               ack_s;
    logic               bypass_s;
    logic               pop_s;
    logic               fifo_pop_s;
    logic               push_s;
    logic               redirect_s;
    logic [31:0]        target_s;
    logic [31:0]        pc_plus4_s;
    logic [31:0]        br_off_s;

    assign imem_req  = (state_q != S_IDLE);
    assign imem_addr = addr_q;

    // An ack only counts while a read is outstanding, so a stray ack is ignored.
    assign ack_s = imem_ack && (state_q != S_IDLE);

`ifdef FETCH_BYPASS_EN
    assign bypass_s = (count_q == CNT_W'(0)) && (state_q == S_BUSY) && imem_ack;
`else
    assign bypass_s = 1'b0;
`endif

    assign pop_s      = inst_valid && inst_ready;
    assign fifo_pop_s = pop_s && (count_q != CNT_W'(0));
    // A bypassed word consumed in its ack cycle never enters the FIFO.
    assign push_s     = ack_s && (state_q == S_BUSY) && !redirect_s && !(bypass_s && pop_s);

    // Decode-side view: FIFO head, else the bypassed ack, else all zeros.
    always_comb begin
        inst_valid = 1'b0;
        inst       = 32'h0000_0000;
        inst_pc    = 32'h0000_0000;
        if (count_q != CNT_W'(0)) begin
            inst_valid = 1'b1;
            inst       = inst_mem_q[head_q];
            inst_pc    = pc_mem_q[head_q];
        end else if (bypass_s) begin
            inst_valid = 1'b1;
            inst       = imem_rdata;
            inst_pc    = addr_q;
        end else begin
            inst_valid = 1'b0;
            inst       = 32'h0000_0000;
            inst_pc    = 32'h0000_0000;
        end
    end

    // Redirect decision for the popped instruction: jr > j > taken branch.
    always_comb begin
        pc_plus4_s = inst_pc + 32'd4;
        br_off_s   = {{14{inst[15]}}, inst[15:0], 2'b00};
        target_s   = pc_plus4_s;
        redirect_s = 1'b0;
        if (pop_s) begin
            if (Jmp == 2'd2) begin
                target_s   = jr_target;
                redirect_s = 1'b1;
            end else if (Jmp == 2'd1) begin
                target_s   = {pc_plus4_s[31:28], inst[25:0], 2'b00};
                redirect_s = 1'b1;
            end else if (BranchAND) begin
                target_s   = pc_plus4_s + br_off_s;
                redirect_s = 1'b1;
            end else begin
                target_s   = pc_plus4_s;
                redirect_s = 1'b0;
            end
        end else begin
            target_s   = pc_plus4_s;
            redirect_s = 1'b0;
        end
    end

    // Request FSM, fetch PC and FIFO pointer next-state logic.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        case (state_q)
            S_IDLE: begin
                // A redirect goes straight to its target; the FIFO empties anyway.
                if (redirect_s) begin
                    state_d = S_BUSY;
                    addr_d  = target_s;
                end else if (count_q < DEPTH_C) begin
                    state_d = S_BUSY;
                    addr_d  = fetch_pc_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (ack_s) begin
                    state_d = S_IDLE;
                end else if (redirect_s) begin
                    state_d = S_DROP;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DROP: begin
                if (ack_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DROP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (redirect_s) begin
            fetch_pc_d = target_s;
        end else if (ack_s && (state_q == S_BUSY)) begin
            fetch_pc_d = addr_q + 32'd4;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        if (redirect_s) begin
            head_d  = PTR_W'(0);
            tail_d  = PTR_W'(0);
            count_d = CNT_W'(0);
        end else begin
            if (push_s) begin
                tail_d = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            if (fifo_pop_s) begin
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            case ({push_s, fifo_pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= 32'h0000_0000;
            head_q     <= PTR_W'(0);
            tail_q     <= PTR_W'(0);
            count_q    <= CNT_W'(0);
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage: write the acked word and its address at the tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                inst_mem_q[i] <= 32'h0000_0000;
                pc_mem_q[i]   <= 32'h0000_0000;
            end
        end else if (push_s) begin
            inst_mem_q[tail_q] <= imem_rdata;
            pc_mem_q[tail_q]   <= addr_q;
        end
    end

endmodule
